// File: rtl/alu_uart_interface_pkg.sv
// Shared definitions for the ALU byte-stream front end: default data width,
// ALU opcode values and a reference evaluation of the TP2 ALU operations.
package alu_uart_interface_pkg;

    localparam int NB_DATA_DEF = 8;

    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SRL = 8'h21;
    localparam logic [7:0] OP_SUB = 8'h22;
    localparam logic [7:0] OP_SRA = 8'h23;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_NOR = 8'h27;

    // Combinational ALU behaviour; unknown opcodes yield zero.
    function automatic logic [7:0] aluCompute(input logic [7:0] a,
                                              input logic [7:0] b,
                                              input logic [7:0] op);
        logic [7:0] result;
        case (op)
            OP_ADD:  result = a + b;
            OP_SRL:  result = a >> b;
            OP_SUB:  result = a - b;
            OP_SRA:  result = $signed(a) >>> b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            default: result = 8'h00;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/alu_uart_interface_if.sv
// Bundle of the UART-side and ALU-side signals seen by the front end.
// The master modport is the front end itself; the slave modport is the
// surrounding UART/ALU logic.
interface alu_uart_interface_if
    import alu_uart_interface_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF
);

    logic [NB_DATA-1:0] rx_data;
    logic               rx_done;
    logic [NB_DATA-1:0] alu_result;
    logic               tx_done;
    logic [NB_DATA-1:0] alu_a;
    logic [NB_DATA-1:0] alu_b;
    logic [NB_DATA-1:0] alu_op;
    logic [NB_DATA-1:0] tx_data;
    logic               tx_start;
    logic               busy;
    logic               drop;

    modport master (
        input  rx_data, rx_done, alu_result, tx_done,
        output alu_a, alu_b, alu_op, tx_data, tx_start, busy, drop
    );

    modport slave (
        output rx_data, rx_done, alu_result, tx_done,
        input  alu_a, alu_b, alu_op, tx_data, tx_start, busy, drop
    );

endinterface

// File: rtl/alu_uart_interface.sv
// Byte-stream front end for the ALU: collects operand A, operand B and the
// opcode from the UART receiver, lets the ALU settle for one cycle, then
// hands the result to the UART transmitter. Bytes arriving while a result
// is in flight are discarded and flagged on drop. A stalled command is
// abandoned after TIMEOUT_CYC idle cycles between bytes (0 disables this).
module alu_uart_interface
    import alu_uart_interface_pkg::*;
#(
    parameter int NB_DATA     = NB_DATA_DEF,
    parameter int TIMEOUT_CYC = 50_000_000
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    alu_uart_interface_if.master bus
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [2:0] {
        ST_WAIT_A,
        ST_WAIT_B,
        ST_WAIT_OP,
        ST_CAPTURE,
        ST_SEND,
        ST_WAIT_TX
    } state_e;

    state_e             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [NB_DATA-1:0] r_aluA;
    logic [NB_DATA-1:0] r_aluB;
    logic [NB_DATA-1:0] r_aluOp;
    logic [NB_DATA-1:0] r_txData;
    logic               r_txStart;
    logic               r_busy;
    logic               r_drop;
    logic               w_expire;

    assign w_expire = (TIMEOUT_CYC > 0) && (r_count == CNT_LAST);

    // Command sequencer: byte collection, result capture, transmit handshake
    // and inter-byte timeout; r_busy mirrors CAPTURE/SEND/WAIT_TX membership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_WAIT_A;
            r_count   <= '0;
            r_aluA    <= '0;
            r_aluB    <= '0;
            r_aluOp   <= '0;
            r_txData  <= '0;
            r_txStart <= 1'b0;
            r_busy    <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_drop    <= bus.rx_done && r_busy;
            r_txStart <= 1'b0;
            case (r_state)
                ST_WAIT_A: begin
                    r_count <= '0;
                    if (bus.rx_done) begin
                        r_aluA  <= bus.rx_data;
                        r_state <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (bus.rx_done) begin
                        r_aluB  <= bus.rx_data;
                        r_count <= '0;
                        r_state <= ST_WAIT_OP;
                    end else if (w_expire) begin
                        r_count <= '0;
                        r_state <= ST_WAIT_A;
                    end else if (TIMEOUT_CYC > 0) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                ST_WAIT_OP: begin
                    if (bus.rx_done) begin
                        r_aluOp <= bus.rx_data;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_CAPTURE;
                    end else if (w_expire) begin
                        r_count <= '0;
                        r_state <= ST_WAIT_A;
                    end else if (TIMEOUT_CYC > 0) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    r_txData  <= bus.alu_result;
                    r_txStart <= 1'b1;
                    r_state   <= ST_SEND;
                end
                ST_SEND: begin
                    r_state <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (bus.tx_done) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_WAIT_A;
                    end
                end
                default: begin
                    r_count <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_WAIT_A;
                end
            endcase
        end
    end

    assign bus.alu_a    = r_aluA;
    assign bus.alu_b    = r_aluB;
    assign bus.alu_op   = r_aluOp;
    assign bus.tx_data  = r_txData;
    assign bus.tx_start = r_txStart;
    assign bus.busy     = r_busy;
    assign bus.drop     = r_drop;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench for alu_uart_interface: the ALU is evaluated from the
// package reference function, UART rx/tx are modelled as single-cycle pulses.
module tb_alu_uart_interface;
    import alu_uart_interface_pkg::*;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   errorCount;

    alu_uart_interface_if #(.NB_DATA(8)) bus ();

    alu_uart_interface #(
        .NB_DATA     (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.alu_result = aluCompute(bus.alu_a, bus.alu_b, bus.alu_op);

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] value);
        bus.rx_data = value;
        bus.rx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
    endtask

    // Sends A, B, opcode and checks the exact tx_start timing and result.
    task automatic applyStimulus(input string tag, input logic [7:0] a,
                                 input logic [7:0] b, input logic [7:0] op,
                                 input logic [7:0] expResult);
        sendByte(a);
        sendByte(b);
        sendByte(op);
        checkOutput({tag, "_busy_capture"}, 32'(bus.busy), 32'd1);
        checkOutput({tag, "_start_early"}, 32'(bus.tx_start), 32'd0);
        tick();
        checkOutput({tag, "_start"}, 32'(bus.tx_start), 32'd1);
        checkOutput({tag, "_txdata"}, 32'(bus.tx_data), 32'(expResult));
        tick();
        checkOutput({tag, "_start_once"}, 32'(bus.tx_start), 32'd0);
        checkOutput({tag, "_txdata_hold"}, 32'(bus.tx_data), 32'(expResult));
    endtask

    task automatic finishTx(input string tag);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        checkOutput({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_a"}, 32'(bus.alu_a), 32'd0);
        checkOutput({tag, "_b"}, 32'(bus.alu_b), 32'd0);
        checkOutput({tag, "_op"}, 32'(bus.alu_op), 32'd0);
        checkOutput({tag, "_txdata"}, 32'(bus.tx_data), 32'd0);
        checkOutput({tag, "_start"}, 32'(bus.tx_start), 32'd0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_drop"}, 32'(bus.drop), 32'd0);
    endtask

    // Directed scenario sequence
    initial begin
        checkCount  = 0;
        errorCount  = 0;
        rst_n       = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_done = 1'b0;
        bus.tx_done = 1'b0;
        #12;
        checkAllZero("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Basic add with latency check
        applyStimulus("add", 8'h05, 8'h03, OP_ADD, 8'h08);
        checkOutput("add_alu_a", 32'(bus.alu_a), 32'h05);
        finishTx("add");

        // Subtract with wrap and arithmetic right shift
        applyStimulus("sub", 8'h05, 8'h07, OP_SUB, 8'hFE);
        finishTx("sub");
        applyStimulus("sra", 8'h80, 8'h01, OP_SRA, 8'hC0);
        finishTx("sra");

        // Byte arriving during WAIT_TX is dropped
        applyStimulus("pre_drop", 8'h12, 8'h34, OP_ADD, 8'h46);
        sendByte(8'hAA);
        checkOutput("drop_pulse", 32'(bus.drop), 32'd1);
        checkOutput("drop_txdata", 32'(bus.tx_data), 32'h46);
        checkOutput("drop_alu_a", 32'(bus.alu_a), 32'h12);
        checkOutput("drop_busy", 32'(bus.busy), 32'd1);
        tick();
        checkOutput("drop_once", 32'(bus.drop), 32'd0);
        finishTx("pre_drop");
        applyStimulus("and", 8'h3C, 8'h0F, OP_AND, 8'h0C);
        finishTx("and");

        // Byte in the expiring cycle still wins (15 idle cycles between bytes)
        sendByte(8'h01);
        repeat (15) tick();
        sendByte(8'h06);
        repeat (15) tick();
        sendByte(OP_OR);
        checkOutput("edge_busy", 32'(bus.busy), 32'd1);
        tick();
        checkOutput("edge_start", 32'(bus.tx_start), 32'd1);
        checkOutput("edge_txdata", 32'(bus.tx_data), 32'h07);
        tick();
        finishTx("edge");

        // 16 idle cycles after A abandons the command
        sendByte(8'h09);
        repeat (16) tick();
        checkOutput("tmo_busy", 32'(bus.busy), 32'd0);
        checkOutput("tmo_keep_a", 32'(bus.alu_a), 32'h09);
        checkOutput("tmo_keep_b", 32'(bus.alu_b), 32'h06);
        applyStimulus("tmo_or", 8'h02, 8'h03, OP_OR, 8'h03);
        checkOutput("tmo_alu_a", 32'(bus.alu_a), 32'h02);
        checkOutput("tmo_alu_b", 32'(bus.alu_b), 32'h03);
        finishTx("tmo_or");

        // Reset mid-command discards the partial command
        sendByte(8'h0A);
        sendByte(8'h0B);
        rst_n = 1'b0;
        #2;
        checkAllZero("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus("xor", 8'h0F, 8'hF0, OP_XOR, 8'hFF);
        checkOutput("xor_alu_a", 32'(bus.alu_a), 32'h0F);
        finishTx("xor");

        // tx_done and rx_done together in WAIT_TX
        applyStimulus("pre_both", 8'h21, 8'h01, OP_ADD, 8'h22);
        bus.rx_data = 8'h77;
        bus.rx_done = 1'b1;
        bus.tx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        bus.tx_done = 1'b0;
        checkOutput("both_drop", 32'(bus.drop), 32'd1);
        checkOutput("both_busy", 32'(bus.busy), 32'd0);
        tick();
        checkOutput("both_drop_once", 32'(bus.drop), 32'd0);
        applyStimulus("post_both", 8'h11, 8'h22, OP_ADD, 8'h33);
        checkOutput("post_both_alu_a", 32'(bus.alu_a), 32'h11);
        finishTx("post_both");

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
